// File: rtl/button_conditioner.sv
// button_conditioner: per-channel input conditioning for raw board buttons and
// switches. Each channel is synchronised, polarity-normalised and debounced,
// then produces a clean level plus press, release and long-press pulses.
// Channels share only the clock and reset; no output depends
// combinationally on a pin.
module button_conditioner #(
  parameter int                NUM_CH          = 3,
  parameter int                DEBOUNCE_CYCLES = 120000,
  parameter int                HOLD_CYCLES     = 1200000,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] btn_async_unsafe_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] release_o,
  output logic [NUM_CH-1:0] hold_o
);

  // Debounce counter holds 0..DEBOUNCE_CYCLES; acceptance happens on the
  // edge where it has already counted DEBOUNCE_CYCLES-1 mismatching samples.
  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Hold counter is only generated when HOLD_CYCLES > 0; keep a legal width
  // otherwise so the declarations below stay well-formed.
  localparam int                HOLD_W   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  // True when the debounce counter is on its final mismatching sample.
  function automatic logic db_done(input logic [DB_W-1:0] cnt);
    return (cnt == DB_LAST);
  endfunction

  // Saturating increment for the hold counter: sticks at HOLD_CYCLES so a
  // long press produces a single hold pulse.
  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] cnt);
    return (cnt == HOLD_MAX) ? cnt : cnt + HOLD_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

    logic            sync_p0;
    logic            sync_p1;
    logic            s_norm;
    logic [DB_W-1:0] db_cnt_p2;
    logic            level_p2;
    logic            press_p2;
    logic            release_p2;

    // Stage p0/p1: two-flop synchroniser; resets to the idle pin level so no
    // spurious activity appears when reset is released.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        sync_p0 <= ACTIVE_LOW_MASK[i];
        sync_p1 <= ACTIVE_LOW_MASK[i];
      end else begin
        sync_p0 <= btn_async_unsafe_i[i];
        sync_p1 <= sync_p0;
      end
    end

    // Normalise so that 1 always means "pressed" downstream.
    assign s_norm = sync_p1 ^ ACTIVE_LOW_MASK[i];

    // Stage p2: debounce; any sample agreeing with the current level discards
    // the partial count, so short glitches never surface.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        db_cnt_p2  <= '0;
        level_p2   <= 1'b0;
        press_p2   <= 1'b0;
        release_p2 <= 1'b0;
      end else begin
        press_p2   <= 1'b0;
        release_p2 <= 1'b0;
        if (s_norm == level_p2) begin
          db_cnt_p2 <= '0;
        end else if (db_done(db_cnt_p2)) begin
          db_cnt_p2  <= '0;
          level_p2   <= s_norm;
          press_p2   <= s_norm;
          release_p2 <= ~s_norm;
        end else begin
          db_cnt_p2 <= db_cnt_p2 + DB_W'(1);
        end
      end
    end

    assign level_o[i]   = level_p2;
    assign press_o[i]   = press_p2;
    assign release_o[i] = release_p2;

    if (HOLD_CYCLES > 0) begin : g_hold

      logic [HOLD_W-1:0] hold_cnt_p2;
      logic              hold_p3;

      // Stage p3: count cycles spent pressed; pulse once when the count first
      // reaches HOLD_CYCLES, re-armed only by the level dropping.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          hold_cnt_p2 <= '0;
          hold_p3     <= 1'b0;
        end else if (!level_p2) begin
          hold_cnt_p2 <= '0;
          hold_p3     <= 1'b0;
        end else begin
          hold_cnt_p2 <= hold_sat_inc(hold_cnt_p2);
          hold_p3     <= (hold_cnt_p2 != HOLD_MAX) &&
                         (hold_sat_inc(hold_cnt_p2) == HOLD_MAX);
        end
      end

      assign hold_o[i] = hold_p3;

    end else begin : g_no_hold

      assign hold_o[i] = 1'b0;

    end

  end

endmodule
